// File: rtl/frame_burst_writer.sv
// rtl/frame_burst_writer.sv - RGB565 packer, word FIFO and ping-pong DDR burst writer
module frame_burst_writer #(
   parameter int                ADDR_W     = 28,
   parameter int                BURST_LEN  = 16,
   parameter int                FIFO_DEPTH = 64,
   parameter logic [ADDR_W-1:0] BASE0      = 28'h000_0000,
   parameter logic [ADDR_W-1:0] BASE1      = 28'h010_0000
) (
   input  logic              pixel_clk,
   input  logic              rst,
   input  logic [15:0]       pdata_i,
   input  logic              de_i,
   input  logic              vs_i,
   output logic              wr_req,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_len,
   input  logic              wr_ack,
   output logic [127:0]      wr_data,
   output logic              wr_valid,
   input  logic              wr_ready,
   output logic              wr_last,
   output logic              rd_buf_sel,
   output logic              frame_done,
   output logic              overflow
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] BL_C    = CNT_W'(BURST_LEN);
   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA} state_t;

   state_t             state_q, state_d;
   logic [127:0]       pack_q, pack_d;
   logic [2:0]         pix_cnt_q, pix_cnt_d;
   logic               de_q, vs_q;
   logic [127:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wptr_q, rptr_q;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [CNT_W-1:0]   flush_q, flush_d;
   logic [7:0]         len_q, len_d;
   logic [7:0]         beat_q, beat_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic               wbuf_q, wbuf_d;
   logic               rd_sel_q, rd_sel_d;
   logic               done_q, done_d;
   logic               ovf_q, ovf_d;

   logic               vs_edge, de_fall;
   logic               push, push_ok, pop, full, empty;
   logic               last_beat, switch_buf;
   logic [127:0]       push_word;

   // Pixel packer: collect 8 pixels per word, pad a partial word at line end or frame sync
   always_comb begin
      vs_edge   = vs_i & ~vs_q;
      de_fall   = de_q & ~de_i;
      pack_d    = pack_q;
      pix_cnt_d = pix_cnt_q;
      push      = 1'b0;
      push_word = pack_q;
      if (de_i && !vs_edge) begin
         pack_d[{pix_cnt_q, 4'b0000} +: 16] = pdata_i;
         if (pix_cnt_q == 3'd7) begin
            push      = 1'b1;
            push_word = pack_d;
            pack_d    = '0;
            pix_cnt_d = '0;
         end else begin
            pix_cnt_d = pix_cnt_q + 3'd1;
         end
      end else if ((vs_edge || de_fall) && pix_cnt_q != 3'd0) begin
         push      = 1'b1;
         push_word = pack_q;
         pack_d    = '0;
         pix_cnt_d = '0;
      end
   end

   // FIFO occupancy, frame flush accounting and buffer-switch decision
   always_comb begin
      full       = (count_q == DEPTH_C);
      empty      = (count_q == '0);
      push_ok    = push & ~full;
      pop        = (state_q == S_DATA) & ~empty & wr_ready;
      last_beat  = pop & ((beat_q + 8'd1) == len_q);
      count_d    = count_q + CNT_W'(push_ok) - CNT_W'(pop);
      ovf_d      = ovf_q | (push & full);
      flush_d    = flush_q;
      switch_buf = 1'b0;
      if (vs_edge) begin
         // a new frame sync before the previous frame drained means it was cut short
         if (flush_q != '0) ovf_d = 1'b1;
         flush_d = count_d;
         if (count_d == '0) switch_buf = 1'b1;
      end else if (pop && flush_q != '0) begin
         flush_d = flush_q - ONE_C;
         if (flush_q == ONE_C) switch_buf = 1'b1;
      end
      beat_d = beat_q;
      if (pop) beat_d = last_beat ? 8'd0 : beat_q + 8'd1;
      addr_d   = addr_q;
      wbuf_d   = wbuf_q;
      rd_sel_d = rd_sel_q;
      done_d   = switch_buf;
      if (switch_buf) begin
         rd_sel_d = wbuf_q;
         wbuf_d   = ~wbuf_q;
         addr_d   = wbuf_q ? BASE0 : BASE1;
      end else if (last_beat) begin
         addr_d = addr_q + ADDR_W'(len_q);
      end
   end

   // FSM state register
   always_ff @(posedge pixel_clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // FSM next state and burst length selection; pending frame flush takes priority
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      case (state_q)
         S_IDLE: begin
            if (flush_q != '0) begin
               state_d = S_REQ;
               len_d   = (flush_q > BL_C) ? 8'(BURST_LEN) : 8'(flush_q);
            end else if (count_q >= BL_C) begin
               state_d = S_REQ;
               len_d   = 8'(BURST_LEN);
            end
         end
         S_REQ:   if (wr_ack) state_d = S_DATA;
         S_DATA:  if (last_beat) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs: request, beat valid/data and last-beat marker
   always_comb begin
      wr_req   = (state_q == S_REQ);
      wr_valid = (state_q == S_DATA) & ~empty;
      wr_data  = wr_valid ? mem[rptr_q] : '0;
      wr_last  = wr_valid & ((beat_q + 8'd1) == len_q);
   end

   // FIFO storage; contents need no reset because the pointers are cleared
   always_ff @(posedge pixel_clk) begin
      if (push_ok) mem[wptr_q] <= push_word;
   end

   // Datapath registers
   always_ff @(posedge pixel_clk or posedge rst) begin
      if (rst) begin
         pack_q    <= '0;
         pix_cnt_q <= '0;
         de_q      <= 1'b0;
         vs_q      <= 1'b0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         count_q   <= '0;
         flush_q   <= '0;
         len_q     <= '0;
         beat_q    <= '0;
         addr_q    <= BASE0;
         wbuf_q    <= 1'b0;
         rd_sel_q  <= 1'b0;
         done_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         pack_q    <= pack_d;
         pix_cnt_q <= pix_cnt_d;
         de_q      <= de_i;
         vs_q      <= vs_i;
         if (push_ok) wptr_q <= wptr_q + 1'b1;
         if (pop)     rptr_q <= rptr_q + 1'b1;
         count_q   <= count_d;
         flush_q   <= flush_d;
         len_q     <= len_d;
         beat_q    <= beat_d;
         addr_q    <= addr_d;
         wbuf_q    <= wbuf_d;
         rd_sel_q  <= rd_sel_d;
         done_q    <= done_d;
         ovf_q     <= ovf_d;
      end
   end

   assign wr_addr    = addr_q;
   assign wr_len     = len_q;
   assign rd_buf_sel = rd_sel_q;
   assign frame_done = done_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_frame_burst_writer.sv
// tb/tb_frame_burst_writer.sv - scoreboard bench for frame_burst_writer
module tb_frame_burst_writer;

   localparam logic [27:0] B0 = 28'h000_0000;
   localparam logic [27:0] B1 = 28'h010_0000;

   logic         pixel_clk = 1'b0;
   logic         rst = 1'b1;
   logic [15:0]  pdata_i = '0;
   logic         de_i = 1'b0;
   logic         vs_i = 1'b0;
   logic         wr_req;
   logic [27:0]  wr_addr;
   logic [7:0]   wr_len;
   logic         wr_ack = 1'b0;
   logic [127:0] wr_data;
   logic         wr_valid;
   logic         wr_ready = 1'b0;
   logic         wr_last;
   logic         rd_buf_sel, frame_done, overflow;

   int total = 0;
   int bad   = 0;

   logic [127:0] exp_data [$];
   logic [35:0]  exp_burst [$];
   logic         exp_sw [$];

   int           ack_mode = 0;     // 0 tied high, 1 held low, 2 delayed
   int           ready_mode = 0;   // 0 tied high, 1 held low, 2 toggling
   int           ack_cnt = 0;

   logic [15:0]  seq = 16'd1;
   logic [127:0] acc = '0;
   int           slot = 0;

   bit           req_pend = 0;
   logic [27:0]  held_addr;
   logic [7:0]   held_len;
   logic [7:0]   cur_len = '0;
   logic [35:0]  mon_e;
   int           beat = 0;

   frame_burst_writer dut (
      .pixel_clk (pixel_clk),
      .rst       (rst),
      .pdata_i   (pdata_i),
      .de_i      (de_i),
      .vs_i      (vs_i),
      .wr_req    (wr_req),
      .wr_addr   (wr_addr),
      .wr_len    (wr_len),
      .wr_ack    (wr_ack),
      .wr_data   (wr_data),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_last   (wr_last),
      .rd_buf_sel(rd_buf_sel),
      .frame_done(frame_done),
      .overflow  (overflow)
   );

   always #5 pixel_clk = ~pixel_clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic fail(input string name, input logic [127:0] act);
      total++;
      bad++;
      $display("FAIL %s: got %h want nothing", name, act);
   endtask

   // write-port responder
   always @(posedge pixel_clk) begin
      #1;
      case (ack_mode)
         0: wr_ack = 1'b1;
         1: wr_ack = 1'b0;
         default: begin
            if (wr_req) begin
               ack_cnt++;
               wr_ack = (ack_cnt == 5);
            end else begin
               ack_cnt = 0;
               wr_ack  = 1'b0;
            end
         end
      endcase
      case (ready_mode)
         0: wr_ready = 1'b1;
         1: wr_ready = 1'b0;
         default: wr_ready = ~wr_ready;
      endcase
   end

   // monitor: pops expectations whenever the DUT presents a request, beat or switch
   always @(negedge pixel_clk) begin
      if (rst) begin
         req_pend = 0;
         beat     = 0;
      end else begin
         if (req_pend)
            chk("req_hold", 128'({wr_req, wr_addr, wr_len}), 128'({1'b1, held_addr, held_len}));
         req_pend = 0;
         if (wr_req) begin
            if (wr_ack) begin
               if (exp_burst.size() == 0) begin
                  fail("burst_unexpected", 128'({wr_addr, wr_len}));
                  cur_len = wr_len;
               end else begin
                  mon_e = exp_burst.pop_front();
                  chk("burst_addr_len", 128'({wr_addr, wr_len}), 128'(mon_e));
                  cur_len = mon_e[7:0];
               end
               beat = 0;
            end else begin
               req_pend  = 1;
               held_addr = wr_addr;
               held_len  = wr_len;
            end
         end
         if (wr_valid && wr_ready) begin
            if (exp_data.size() == 0) fail("beat_unexpected", wr_data);
            else chk("beat_data", wr_data, exp_data.pop_front());
            chk("beat_last", 128'(wr_last), 128'(beat + 1 == int'(cur_len)));
            beat++;
         end
         if (frame_done) begin
            if (exp_sw.size() == 0) fail("switch_unexpected", 128'(rd_buf_sel));
            else chk("rd_buf_sel", 128'(rd_buf_sel), 128'(exp_sw.pop_front()));
         end
      end
   end

   task automatic send_line(input int npix, input bit record);
      for (int i = 0; i < npix; i++) begin
         @(posedge pixel_clk); #1;
         de_i    = 1'b1;
         pdata_i = seq;
         acc[slot*16 +: 16] = seq;
         slot++;
         seq++;
         if (slot == 8) begin
            if (record) exp_data.push_back(acc);
            acc  = '0;
            slot = 0;
         end
      end
      @(posedge pixel_clk); #1;
      de_i    = 1'b0;
      pdata_i = '0;
      if (slot != 0) begin
         if (record) exp_data.push_back(acc);
         acc  = '0;
         slot = 0;
      end
      repeat (4) @(posedge pixel_clk);
      #1;
   endtask

   task automatic vs_pulse();
      @(posedge pixel_clk); #1;
      vs_i = 1'b1;
      @(posedge pixel_clk); #1;
      vs_i = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((exp_data.size() != 0 || exp_burst.size() != 0 || exp_sw.size() != 0) && n < 3000) begin
         @(posedge pixel_clk);
         n++;
      end
      if (n >= 3000) fail({name, "_timeout"}, 128'(exp_data.size()));
      repeat (3) @(posedge pixel_clk);
      #1;
   endtask

   initial begin
      int n;
      rst = 1'b1;
      repeat (3) @(posedge pixel_clk);
      #1;
      chk("rst_wr_req",   128'(wr_req), 128'(0));
      chk("rst_wr_addr",  128'(wr_addr), 128'(B0));
      chk("rst_wr_len",   128'(wr_len), 128'(0));
      chk("rst_wr_valid", 128'(wr_valid), 128'(0));
      chk("rst_wr_last",  128'(wr_last), 128'(0));
      chk("rst_wr_data",  wr_data, 128'(0));
      chk("rst_rd_sel",   128'(rd_buf_sel), 128'(0));
      chk("rst_done",     128'(frame_done), 128'(0));
      chk("rst_ovf",      128'(overflow), 128'(0));
      rst = 1'b0;
      repeat (2) @(posedge pixel_clk);
      #1;

      // 320x2 frame: 80 words as five bursts of 16 into buffer 0
      for (int b = 0; b < 5; b++) exp_burst.push_back({B0 + 28'(16 * b), 8'd16});
      send_line(320, 1);
      send_line(320, 1);
      drain("frame320");
      exp_sw.push_back(1'b0);
      vs_pulse();
      drain("switch0");
      chk("next_base_b1", 128'(wr_addr), 128'(B1));
      chk("done_pulse_ends", 128'(frame_done), 128'(0));

      // packing: full word of 1..8, then a padded 3-pixel line, flushed by vs
      exp_data.push_back(128'h0008_0007_0006_0005_0004_0003_0002_0001);
      exp_data.push_back(128'h0000_0000_0000_0000_0000_0003_0002_0001);
      exp_burst.push_back({B1, 8'd2});
      exp_sw.push_back(1'b1);
      seq = 16'd1;
      send_line(8, 0);
      seq = 16'd1;
      send_line(3, 0);
      vs_pulse();
      drain("pack_flush");
      chk("next_base_b0", 128'(wr_addr), 128'(B0));

      // 40 words held back, vs, new-frame words queued behind the flush
      ack_mode = 1;
      exp_burst.push_back({B0, 8'd16});
      exp_burst.push_back({B0 + 28'd16, 8'd16});
      exp_burst.push_back({B0 + 28'd32, 8'd8});
      send_line(320, 1);
      exp_sw.push_back(1'b0);
      vs_pulse();
      send_line(64, 1);
      ack_mode = 0;
      n = 0;
      while (exp_sw.size() != 0 && n < 500) begin
         @(posedge pixel_clk);
         n++;
      end
      repeat (3) @(posedge pixel_clk);
      #1;
      chk("new_frame_held", 128'(exp_data.size()), 128'(8));
      chk("flush_bursts_done", 128'(exp_burst.size()), 128'(0));
      exp_burst.push_back({B1, 8'd16});
      send_line(64, 1);
      drain("new_frame");
      exp_sw.push_back(1'b1);
      vs_pulse();
      drain("switch1");

      // delayed ack and toggling ready
      ack_mode   = 2;
      ready_mode = 2;
      exp_burst.push_back({B0, 8'd16});
      exp_burst.push_back({B0 + 28'd16, 8'd16});
      repeat (4) send_line(64, 1);
      drain("backpressure");
      ack_mode   = 0;
      ready_mode = 0;
      exp_sw.push_back(1'b0);
      vs_pulse();
      drain("switch2");

      // overflow with ready held low
      ready_mode = 1;
      for (int b = 0; b < 4; b++) exp_burst.push_back({B1 + 28'(16 * b), 8'd16});
      send_line(512, 1);
      chk("ovf_after_64", 128'(overflow), 128'(0));
      send_line(8, 0);
      chk("ovf_after_65", 128'(overflow), 128'(1));
      send_line(40, 0);
      ready_mode = 0;
      drain("overflow");
      chk("ovf_sticky", 128'(overflow), 128'(1));
      exp_sw.push_back(1'b1);
      vs_pulse();
      drain("switch3");

      // reset in the middle of a stalled burst
      exp_burst.push_back({B0, 8'd16});
      send_line(128, 1);
      drain("pre_reset");
      ready_mode = 1;
      exp_burst.push_back({B0 + 28'd16, 8'd16});
      send_line(128, 1);
      n = 0;
      while (!wr_valid && n < 100) begin
         @(posedge pixel_clk); #1;
         n++;
      end
      chk("in_data_before_rst", 128'(wr_valid), 128'(1));
      @(posedge pixel_clk); #3;
      rst = 1'b1;
      #1;
      chk("arst_wr_valid", 128'(wr_valid), 128'(0));
      chk("arst_wr_req",   128'(wr_req), 128'(0));
      chk("arst_wr_addr",  128'(wr_addr), 128'(B0));
      chk("arst_wr_len",   128'(wr_len), 128'(0));
      chk("arst_wr_data",  wr_data, 128'(0));
      chk("arst_wr_last",  128'(wr_last), 128'(0));
      chk("arst_ovf",      128'(overflow), 128'(0));
      chk("arst_rd_sel",   128'(rd_buf_sel), 128'(0));
      exp_data.delete();
      repeat (2) @(posedge pixel_clk);
      #1;
      rst = 1'b0;
      ready_mode = 0;
      exp_burst.push_back({B0, 8'd16});
      send_line(128, 1);
      drain("post_reset");

      chk("end_data_q",  128'(exp_data.size()), 128'(0));
      chk("end_burst_q", 128'(exp_burst.size()), 128'(0));
      chk("end_sw_q",    128'(exp_sw.size()), 128'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
